// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store engine owning the word-addressed data RAM (optional LSU_MISALIGN_TRAP_EN traps misaligned accesses)
module load_store_unit #(
  parameter int COUNT_RAM_WORD = 1024,
  parameter int SIZE_WORD = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [SIZE_WORD-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [SIZE_WORD-1:0] resp_rdata,
  output logic                 resp_err
);
  localparam int AW = $clog2(COUNT_RAM_WORD);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic we;
  logic [2:0] funct3;
  logic [AW+1:0] addr;
  logic [SIZE_WORD-1:0] wdata, word, wd, shifted, rdata;
  logic [SIZE_WORD-1:0] mem [COUNT_RAM_WORD];
  logic err;
  logic [1:0] lane;
  logic [3:0] be;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];
  assign req_ready = state == IDLE;
  // decode the latched request: error, lane (silently aligned), byte enables, write data, extended load data
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    err = (we ? funct3 >= 3'd3 : (funct3[1:0] == 2'b11 || funct3 == 3'b110))
        | (funct3[1] ? addr[1:0] != 2'b00 : funct3[0] & addr[0]);
`else
    err = we ? funct3 >= 3'd3 : (funct3[1:0] == 2'b11 || funct3 == 3'b110);
`endif
    lane = addr[1:0] & (funct3[1] ? 2'b00 : funct3[0] ? 2'b10 : 2'b11);
    be = funct3[1] ? 4'b1111 : funct3[0] ? 4'b0011 << lane : 4'b0001 << lane;
    wd = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    shifted = word >> {lane, 3'b000};
    rdata = (err | we) ? '0
          : funct3[1] ? word
          : funct3[0] ? {{16{~funct3[2] & shifted[15]}}, shifted[15:0]}
          : {{24{~funct3[2] & shifted[7]}}, shifted[7:0]};
  end
  // request latch, three-state sequencer, load capture and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      we <= 1'b0;
      funct3 <= '0;
      addr <= '0;
      wdata <= '0;
      word <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state == IDLE ? (req_valid ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
      resp_valid <= state == RESP;
      resp_rdata <= state == RESP ? rdata : '0;
      resp_err <= state == RESP && err;
      if (req_valid && req_ready) begin
        we <= req_we;
        funct3 <= req_funct3;
        addr <= req_addr[AW+1:0];
        wdata <= req_wdata;
      end
      if (state == ACCESS) word <= mem[addr[AW+1:2]];
    end
  end
  // lane-masked store; an async reset clears state before this edge so an interrupted store never commits
  always_ff @(posedge clk) begin
    if (state == ACCESS && we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, reset corners, back-to-back and random checks against a byte-level model
module tb_load_store_unit;
  localparam int N = 1024;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef struct {
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic err;
  } vec_t;
  logic clk = 0, rst = 0, req_valid = 0, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int n_checks = 0, n_fail = 0;
  logic [7:0] bm [4*N];
  vec_t v[$];

  always #5 clk = ~clk;

  load_store_unit #(.COUNT_RAM_WORD(N), .SIZE_WORD(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int size, a;
    logic bad;
    size = 1 << f3[1:0];
    bad = f3[1:0] == 2'b11 || f3 == 3'b110 || (we && f3[2]);
    a = int'(addr % (4 * N));
    err = bad || (TRAP && (a % size != 0));
    if (!TRAP) a = a - a % size;
    rdata = 0;
    if (err) return;
    for (int i = 0; i < size; i++)
      if (we) bm[a+i] = wdata[8*i +: 8];
      else rdata[8*i +: 8] = bm[a+i];
    if (!we && !f3[2] && size < 4 && rdata[8*size-1]) rdata = rdata | (32'hFFFF_FFFF << (8 * size));
  endfunction

  task automatic transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", {31'd0, req_ready}, 1);
    @(posedge clk);
    #1;
    req_valid = 0; req_we = $urandom; req_funct3 = $urandom; req_addr = $urandom; req_wdata = $urandom;
    check("access_ready_valid", {30'd0, req_ready, resp_valid}, 0);
    @(posedge clk);
    #1;
    check("resp_state_ready_valid", {30'd0, req_ready, resp_valid}, 0);
    @(posedge clk);
    #1;
    check("resp_valid_at_e2", {31'd0, resp_valid}, 1);
    rdata = resp_rdata;
    err = resp_err;
  endtask

  task automatic run_vec(input string name, input vec_t t);
    logic [31:0] mr, r;
    logic me, e;
    model(t.we, t.f3, t.addr, t.wdata, mr, me);
    transact(t.we, t.f3, t.addr, t.wdata, r, e);
    check(name, r, t.rdata);
    check({name, "_err"}, {31'd0, e}, {31'd0, t.err});
  endtask

  task automatic run_model(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mr, r;
    logic me, e;
    model(we, f3, addr, wdata, mr, me);
    transact(we, f3, addr, wdata, r, e);
    check(name, r, mr);
    check({name, "_err"}, {31'd0, e}, {31'd0, me});
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready_valid_err"}, {29'd0, req_ready, resp_valid, resp_err}, 32'b100);
    check({name, "_rdata"}, resp_rdata, 0);
  endtask

  initial begin
    logic [31:0] mr;
    logic me, seen;
    logic [9:1] pat;
    #2 rst = 1;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 0;
    v.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    v.push_back('{1'b1, 3'd0, 32'h13, 32'h123456AA, 32'h0, 1'b0});
    v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'hAAADBEEF, 1'b0});
    v.push_back('{1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFAA, 1'b0});
    v.push_back('{1'b0, 3'd4, 32'h13, 32'h0, 32'h000000AA, 1'b0});
    v.push_back('{1'b1, 3'd1, 32'h12, 32'h00008001, 32'h0, 1'b0});
    v.push_back('{1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF8001, 1'b0});
    v.push_back('{1'b0, 3'd5, 32'h12, 32'h0, 32'h00008001, 1'b0});
    v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'h8001BEEF, 1'b0});
    v.push_back('{1'b0, 3'd2, 32'h11, 32'h0, TRAP ? 32'h0 : 32'h8001BEEF, TRAP});
    v.push_back('{1'b1, 3'd2, 32'h11, 32'hFFFFFFFF, 32'h0, TRAP});
    v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, TRAP ? 32'h8001BEEF : 32'hFFFFFFFF, 1'b0});
    v.push_back('{1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1});
    v.push_back('{1'b0, 3'd6, 32'h10, 32'h0, 32'h0, 1'b1});
    v.push_back('{1'b1, 3'd2, 32'h10 + 4 * N, 32'hCAFEF00D, 32'h0, 1'b0});
    v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0});
    v.push_back('{1'b1, 3'd3, 32'h10, 32'h11111111, 32'h0, 1'b1});
    v.push_back('{1'b1, 3'd4, 32'h10, 32'h22222222, 32'h0, 1'b1});
    v.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0});
    v.push_back('{1'b1, 3'd2, 32'h20, 32'h0, 32'h0, 1'b0});
    foreach (v[i]) run_vec($sformatf("vec%0d", i), v[i]);

    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 0;
    #2 rst = 1;
    #1 check_reset_outputs("rst_in_access");
    #2 rst = 0;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1 seen |= resp_valid;
    end
    check("no_resp_after_access_rst", {31'd0, seen}, 0);
    run_model("lw_after_access_rst", 1'b0, 3'd2, 32'h20, 32'h0);

    model(1'b1, 3'd2, 32'h24, 32'hA5A55A5A, mr, me);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h24; req_wdata = 32'hA5A55A5A;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    #2 check_reset_outputs("rst_in_resp");
    rst = 0;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1 seen |= resp_valid;
    end
    check("no_resp_after_resp_rst", {31'd0, seen}, 0);
    run_model("lw_after_resp_rst", 1'b0, 3'd2, 32'h24, 32'h0);

    for (int w = 0; w < 64; w++) run_model("preload", 1'b1, 3'd2, 32'(4 * w), $urandom);
    for (int k = 0; k < 300; k++)
      run_model("random", 1'($urandom), 3'($urandom), ($urandom & 32'hFFFF_F000) | $urandom_range(0, 255), $urandom);

    model(1'b0, 3'd2, 32'h40, 32'h0, mr, me);
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h0;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1 pat[k] = resp_valid;
      if (resp_valid) check("b2b_rdata", resp_rdata, mr);
    end
    req_valid = 0;
    check("b2b_pulse_pattern", {23'd0, pat}, 32'b010010010);
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
